// File: rtl/unified_sram_arbiter.sv
// unified_sram_arbiter: shares one single-port synchronous SRAM between the
// instruction-fetch (IF) and data (EX) requesters. Data has priority, but
// after STARVE_MAX consecutive fetch denials the fetch side wins one
// contested cycle. Read data comes back one cycle after the grant, to the
// side that owned the access.
// Optional macro ARB_PERF_CNT_EN adds the conflict_cnt / starve_win_cnt outputs.
module unified_sram_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rvalid,
  output logic              i_stall,
  input  logic              d_req,
  input  logic [3:0]        d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              d_stall,
  output logic              m_en,
  output logic [3:0]        m_wen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       conflict_cnt,
  output logic [31:0]       starve_win_cnt
`endif
);

  typedef enum logic [1:0] {NONE, INST_PEND, DATA_PEND} owner_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  owner_e            owner_q, owner_d;
  logic [3:0]        starve_cnt;
  logic              starve_hit, grant_i, grant_d;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

  assign starve_hit = (starve_cnt == STARVE_LIM);

  // Grant: data wins contested cycles unless fetch has been starved out.
  // Grants are masked while reset is held so the SRAM port goes quiet at once.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (rst) begin
      if (i_req && (!d_req || starve_hit)) grant_i = 1'b1;
      else if (d_req)                      grant_d = 1'b1;
    end
  end

  // Shared-port mux; everything is zero when nobody owns the port.
  always_comb begin
    m_en    = 1'b0;
    m_wen   = 4'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (grant_i) begin
      m_en   = 1'b1;
      m_addr = i_addr;
    end else if (grant_d) begin
      m_en    = 1'b1;
      m_wen   = d_wen;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end
  end

  assign i_stall = i_req & ~grant_i & rst;
  assign d_stall = d_req & ~grant_d & rst;

  // Starvation counter: counts consecutive fetch denials, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     starve_cnt <= 4'd0;
    else if (grant_i || !i_req)   starve_cnt <= 4'd0;
    else if (!starve_hit)         starve_cnt <= starve_cnt + 4'd1;
  end

  // Owner state register: remembers who owns the read returning next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) owner_q <= NONE;
    else      owner_q <= owner_d;
  end

  // Owner next state and return steering; writes never enter a pending state.
  always_comb begin
    owner_d  = NONE;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    i_rdata  = i_rdata_q;
    d_rdata  = d_rdata_q;
    if (grant_i)                      owner_d = INST_PEND;
    else if (grant_d && d_wen == 4'b0) owner_d = DATA_PEND;
    case (owner_q)
      INST_PEND: begin
        i_rvalid = 1'b1;
        i_rdata  = m_rdata;
      end
      DATA_PEND: begin
        d_rvalid = 1'b1;
        d_rdata  = m_rdata;
      end
      default: ;
    endcase
  end

  // Hold the last returned word for each side between returns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (owner_q == INST_PEND) i_rdata_q <= m_rdata;
      if (owner_q == DATA_PEND) d_rdata_q <= m_rdata;
    end
  end

`ifdef ARB_PERF_CNT_EN
  // Performance counters: contested cycles and starvation-rule fetch wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt   <= 32'd0;
      starve_win_cnt <= 32'd0;
    end else begin
      if (i_req && d_req)   conflict_cnt   <= conflict_cnt + 32'd1;
      if (grant_i && d_req) starve_win_cnt <= starve_win_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_unified_sram_arbiter.sv
// Directed bench for unified_sram_arbiter: a vector table for single-cycle
// behaviour plus hand-written sequences for starvation and reset mid-read.
module tb_unified_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_wen;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_rvalid, i_stall, d_rvalid, d_stall, m_en;
  logic [3:0]  m_wen;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt, starve_win_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  unified_sram_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_stall(i_stall),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_stall(d_stall),
    .m_en(m_en), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
`ifdef ARB_PERF_CNT_EN
    , .conflict_cnt(conflict_cnt), .starve_win_cnt(starve_win_cnt)
`endif
  );

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic [3:0]  d_wen;
    logic [31:0] d_addr, d_wdata, m_rdata;
    logic        m_en;
    logic [3:0]  m_wen;
    logic [31:0] m_addr, m_wdata;
    logic        i_stall, d_stall, i_rvalid, d_rvalid;
    logic [31:0] i_rdata, d_rdata;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input int n, input vec_t v);
    string p;
    p = $sformatf("vec%0d", n);
    chk({p, ".m_en"},     {31'b0, m_en},     {31'b0, v.m_en});
    chk({p, ".m_wen"},    {28'b0, m_wen},    {28'b0, v.m_wen});
    chk({p, ".m_addr"},   m_addr,            v.m_addr);
    chk({p, ".m_wdata"},  m_wdata,           v.m_wdata);
    chk({p, ".i_stall"},  {31'b0, i_stall},  {31'b0, v.i_stall});
    chk({p, ".d_stall"},  {31'b0, d_stall},  {31'b0, v.d_stall});
    chk({p, ".i_rvalid"}, {31'b0, i_rvalid}, {31'b0, v.i_rvalid});
    chk({p, ".d_rvalid"}, {31'b0, d_rvalid}, {31'b0, v.d_rvalid});
    chk({p, ".i_rdata"},  i_rdata,           v.i_rdata);
    chk({p, ".d_rdata"},  d_rdata,           v.d_rdata);
  endtask

  task automatic drive_idle();
    i_req = 0; i_addr = 0; d_req = 0; d_wen = 0; d_addr = 0; d_wdata = 0; m_rdata = 0;
  endtask

  initial begin
    logic        exp_i, prev_i;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] cc0, sw0;
`endif
    //            i_req i_addr        d_req d_wen d_addr        d_wdata       m_rdata     | m_en m_wen m_addr        m_wdata       is ds iv dv i_rdata       d_rdata
    vecs[0]  = '{0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        32'h0,        0, 4'h0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        32'h0};
    vecs[1]  = '{1, 32'hBFC00000, 0, 4'h0, 32'h0,        32'h0,        32'h0,        1, 4'h0, 32'hBFC00000, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0};
    vecs[2]  = '{0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        32'h3C08BFAF, 0, 4'h0, 32'h0,        32'h0,        0, 0, 1, 0, 32'h3C08BFAF, 32'h0};
    vecs[3]  = '{0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        32'hDEADBEEF, 0, 4'h0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h3C08BFAF, 32'h0};
    vecs[4]  = '{1, 32'h100,      1, 4'h0, 32'h80001000, 32'hAAAA5555, 32'h0,        1, 4'h0, 32'h80001000, 32'hAAAA5555, 1, 0, 0, 0, 32'h3C08BFAF, 32'h0};
    vecs[5]  = '{0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        32'h11223344, 0, 4'h0, 32'h0,        32'h0,        0, 0, 0, 1, 32'h3C08BFAF, 32'h11223344};
    vecs[6]  = '{0, 32'h0,        1, 4'h3, 32'h80000010, 32'h12345678, 32'h0,        1, 4'h3, 32'h80000010, 32'h12345678, 0, 0, 0, 0, 32'h3C08BFAF, 32'h11223344};
    vecs[7]  = '{0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        32'h55555555, 0, 4'h0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h3C08BFAF, 32'h11223344};
    vecs[8]  = '{1, 32'h4,        0, 4'h0, 32'h0,        32'h0,        32'h0,        1, 4'h0, 32'h4,        32'h0,        0, 0, 0, 0, 32'h3C08BFAF, 32'h11223344};
    vecs[9]  = '{1, 32'h8,        0, 4'h0, 32'h0,        32'h0,        32'hA0A0A0A0, 1, 4'h0, 32'h8,        32'h0,        0, 0, 1, 0, 32'hA0A0A0A0, 32'h11223344};
    vecs[10] = '{0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        32'hB0B0B0B0, 0, 4'h0, 32'h0,        32'h0,        0, 0, 1, 0, 32'hB0B0B0B0, 32'h11223344};
    vecs[11] = '{1, 32'hC,        1, 4'hF, 32'h80000020, 32'hCAFEF00D, 32'h0,        1, 4'hF, 32'h80000020, 32'hCAFEF00D, 1, 0, 0, 0, 32'hB0B0B0B0, 32'h11223344};
    vecs[12] = '{0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        32'h77,       0, 4'h0, 32'h0,        32'h0,        0, 0, 0, 0, 32'hB0B0B0B0, 32'h11223344};

    // Reset with both sides requesting: port and stalls must stay at zero.
    rst = 0;
    drive_idle();
    i_req = 1; i_addr = 32'h10; d_req = 1; d_addr = 32'h20; d_wen = 4'h1;
    #12;
    chk("rst.m_en",    {31'b0, m_en},    32'h0);
    chk("rst.m_wen",   {28'b0, m_wen},   32'h0);
    chk("rst.m_addr",  m_addr,           32'h0);
    chk("rst.i_stall", {31'b0, i_stall}, 32'h0);
    chk("rst.d_stall", {31'b0, d_stall}, 32'h0);
    chk("rst.rvalid",  {30'b0, i_rvalid, d_rvalid}, 32'h0);
    chk("rst.rdata",   i_rdata | d_rdata, 32'h0);
    @(negedge clk);
    drive_idle();
    rst = 1;

    // Table-driven vectors, one per cycle.
    for (int n = 0; n < 13; n++) begin
      @(negedge clk);
      i_req = vecs[n].i_req; i_addr = vecs[n].i_addr;
      d_req = vecs[n].d_req; d_wen = vecs[n].d_wen;
      d_addr = vecs[n].d_addr; d_wdata = vecs[n].d_wdata; m_rdata = vecs[n].m_rdata;
      #4;
      chk_vec(n, vecs[n]);
    end

    // Starvation: continuous contention, fetch wins on cycles 4 and 9.
`ifdef ARB_PERF_CNT_EN
    cc0 = conflict_cnt;
    sw0 = starve_win_cnt;
`endif
    prev_i = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      i_req = 1; i_addr = 32'h1000; d_req = 1; d_wen = 0; d_addr = 32'h2000;
      d_wdata = 0; m_rdata = 32'h5000 + k;
      exp_i = (k == 4) || (k == 9);
      #4;
      chk($sformatf("starve%0d.m_addr", k), m_addr, exp_i ? 32'h1000 : 32'h2000);
      chk($sformatf("starve%0d.i_stall", k), {31'b0, i_stall}, {31'b0, !exp_i});
      chk($sformatf("starve%0d.d_stall", k), {31'b0, d_stall}, {31'b0, exp_i});
      if (k > 0) begin
        chk($sformatf("starve%0d.i_rvalid", k), {31'b0, i_rvalid}, {31'b0, prev_i});
        chk($sformatf("starve%0d.d_rvalid", k), {31'b0, d_rvalid}, {31'b0, !prev_i});
      end
      prev_i = exp_i;
    end
    @(negedge clk);
    drive_idle();
    m_rdata = 32'hFEED0009;
    #4;
    chk("starve.end.i_rvalid", {31'b0, i_rvalid}, 32'h1);
    chk("starve.end.i_rdata",  i_rdata, 32'hFEED0009);
`ifdef ARB_PERF_CNT_EN
    chk("perf.conflict_cnt",   conflict_cnt - cc0,   32'd10);
    chk("perf.starve_win_cnt", starve_win_cnt - sw0, 32'd2);
`endif

    // Reset while an instruction read is in flight.
    @(negedge clk);
    drive_idle();
    i_req = 1; i_addr = 32'h40;
    @(negedge clk);
    m_rdata = 32'h99999999;
    rst = 0;
    #1;
    chk("rstmid.i_rvalid", {31'b0, i_rvalid}, 32'h0);
    chk("rstmid.i_rdata",  i_rdata, 32'h0);
    chk("rstmid.d_rdata",  d_rdata, 32'h0);
    chk("rstmid.m_en",     {31'b0, m_en}, 32'h0);
    chk("rstmid.m_addr",   m_addr, 32'h0);
    chk("rstmid.i_stall",  {31'b0, i_stall}, 32'h0);
    @(negedge clk);
    rst = 1;
    i_req = 0;
    #4;
    chk("rstrel0.i_rvalid", {31'b0, i_rvalid}, 32'h0);
    @(negedge clk);
    #4;
    chk("rstrel1.i_rvalid", {31'b0, i_rvalid}, 32'h0);
    chk("rstrel1.i_rdata",  i_rdata, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
